// File: rtl/simf_wr_decode_queue_pkg.sv
// simf_wr_decode_queue_pkg: SIMF format codes, opcode ranges, destination constants and decoded-enable struct.
package simf_wr_decode_queue_pkg;

    localparam logic [7:0] ALU_VOP1_FORMAT  = 8'h02;
    localparam logic [7:0] ALU_VOP2_FORMAT  = 8'h04;
    localparam logic [7:0] ALU_VOPC_FORMAT  = 8'h08;
    localparam logic [7:0] ALU_VOP3A_FORMAT = 8'h10;

    localparam logic [11:0] CMP_LO_LAST  = 12'h006;
    localparam logic [11:0] CMP_HI_FIRST = 12'h009;
    localparam logic [11:0] CMP_HI_LAST  = 12'h00F;

    localparam logic [11:0] VCC_DEST_ADDR     = 12'hE01;
    localparam logic [2:0]  SGPR_RANGE_PREFIX = 3'b110;

    typedef struct packed {
        logic vcc;
        logic vgpr;
        logic sgpr;
        logic illegal;
    } dec_en_t;

    // Compare ops 0x007/0x008 are deliberately excluded from the compare range.
    function automatic logic is_cmp_op(input logic [11:0] op);
        return op <= CMP_LO_LAST || (op >= CMP_HI_FIRST && op <= CMP_HI_LAST);
    endfunction

    function automatic logic is_vop2_vgpr_op(input logic [11:0] op);
        return op inside {12'h003, 12'h004, 12'h005, 12'h008, 12'h010, 12'h01F, 12'h020};
    endfunction

    function automatic logic is_vop1_vgpr_op(input logic [11:0] op);
        return op inside {12'h006, 12'h007, 12'h02A, 12'h033};
    endfunction

    function automatic logic is_vop3_vgpr_op(input logic [11:0] op);
        return op inside {12'h103, 12'h104, 12'h105, 12'h108, 12'h141};
    endfunction

endpackage

// File: rtl/simf_wr_decode_queue_if.sv
// simf_wr_decode_queue_if: issue-side and writeback-side valid/ready bundle of the SIMF decode queue.
interface simf_wr_decode_queue_if #(
    parameter int ADDR_W = 12,
    parameter int WFID_W = 6
);
    logic              in_valid;
    logic              in_rdy;
    logic [31:0]       in_opcode;
    logic [ADDR_W-1:0] in_sgpr_dest_addr;
    logic [WFID_W-1:0] in_wfid;
    logic              out_valid;
    logic              out_rdy;
    logic              out_vcc_wr_en;
    logic              out_vgpr_wr_en;
    logic              out_sgpr_wr_en;
    logic              out_illegal;
    logic [WFID_W-1:0] out_wfid;

    modport slave (
        input  in_valid, in_opcode, in_sgpr_dest_addr, in_wfid, out_rdy,
        output in_rdy, out_valid, out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en, out_illegal, out_wfid
    );

    modport master (
        output in_valid, in_opcode, in_sgpr_dest_addr, in_wfid, out_rdy,
        input  in_rdy, out_valid, out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en, out_illegal, out_wfid
    );
endinterface

// File: rtl/simf_wr_decode_logic.sv
// simf_wr_decode_logic: combinational SIMF opcode/destination to VCC/VGPR/SGPR write-enable decode.
module simf_wr_decode_logic
    import simf_wr_decode_queue_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic [31:0]       i_opcode,
    input  logic [ADDR_W-1:0] i_dest,
    output dec_en_t           o_en
);
    logic [7:0]  w_fmt;
    logic [11:0] w_op;
    logic        w_vgpr;
    logic        w_vopc;
    logic        w_cmp3;
    logic        w_dest_vcc;
    logic        w_dest_sgpr;
    logic        w_unused;

    assign w_fmt       = i_opcode[31:24];
    assign w_op        = i_opcode[11:0];
    assign w_unused    = ^i_opcode[23:12];
    assign w_vgpr      = (w_fmt == ALU_VOP2_FORMAT  && is_vop2_vgpr_op(w_op)) ||
                         (w_fmt == ALU_VOP1_FORMAT  && is_vop1_vgpr_op(w_op)) ||
                         (w_fmt == ALU_VOP3A_FORMAT && is_vop3_vgpr_op(w_op));
    assign w_vopc      = w_fmt == ALU_VOPC_FORMAT  && is_cmp_op(w_op);
    assign w_cmp3      = w_fmt == ALU_VOP3A_FORMAT && is_cmp_op(w_op);
    assign w_dest_vcc  = i_dest == ADDR_W'(VCC_DEST_ADDR);
    assign w_dest_sgpr = i_dest[ADDR_W-1 -: 3] == SGPR_RANGE_PREFIX;

    // A VOP3A compare writes both VCC and SGPR unless the destination pins it to one of them.
    assign o_en = '{
        vcc:     w_vopc || (w_cmp3 && !w_dest_sgpr),
        vgpr:    w_vgpr,
        sgpr:    w_cmp3 && !w_dest_vcc,
        illegal: !(w_vgpr || w_vopc || w_cmp3)
    };
endmodule

// File: rtl/simf_wr_decode_queue.sv
// simf_wr_decode_queue: SIMF write-enable decoder feeding a DEPTH-entry valid/ready FIFO.
// Define SIMF_DEC_STATS_EN to add saturating issued/illegal push counters.
module simf_wr_decode_queue
    import simf_wr_decode_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int WFID_W = 6,
    parameter int CNT_W  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
`ifdef SIMF_DEC_STATS_EN
    input  logic             i_stats_clr,
    output logic [CNT_W-1:0] o_stat_issued,
    output logic [CNT_W-1:0] o_stat_illegal,
`endif
    simf_wr_decode_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        dec_en_t           en;
        logic [WFID_W-1:0] wfid;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    dec_en_t          w_en;
    entry_t           w_head;
    logic             w_push;
    logic             w_pop;

    simf_wr_decode_logic #(.ADDR_W(ADDR_W)) u_dec (
        .i_opcode (bus.in_opcode),
        .i_dest   (bus.in_sgpr_dest_addr),
        .o_en     (w_en)
    );

    // Ready comes only from the occupancy register, never from out_rdy.
    assign bus.in_rdy    = r_count != (PTR_W+1)'(DEPTH);
    assign bus.out_valid = r_count != '0;
    assign w_push        = bus.in_valid && bus.in_rdy;
    assign w_pop         = bus.out_valid && bus.out_rdy;

    // Storage is not reset, so the head is masked to zero while the queue is empty.
    assign w_head             = bus.out_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.out_vcc_wr_en  = w_head.en.vcc;
    assign bus.out_vgpr_wr_en = w_head.en.vgpr;
    assign bus.out_sgpr_wr_en = w_head.en.sgpr;
    assign bus.out_illegal    = w_head.en.illegal;
    assign bus.out_wfid       = w_head.wfid;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{en: w_en, wfid: bus.in_wfid};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end

`ifdef SIMF_DEC_STATS_EN
    logic [CNT_W-1:0] r_stat_issued;
    logic [CNT_W-1:0] r_stat_illegal;

    assign o_stat_issued  = r_stat_issued;
    assign o_stat_illegal = r_stat_illegal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_issued  <= '0;
            r_stat_illegal <= '0;
        end else begin
            r_stat_issued  <= i_stats_clr ? '0 : (w_push && ~&r_stat_issued) ? r_stat_issued + 1'b1 : r_stat_issued;
            r_stat_illegal <= i_stats_clr ? '0 : (w_push && w_en.illegal && ~&r_stat_illegal) ? r_stat_illegal + 1'b1 : r_stat_illegal;
        end
    end
`else
    localparam int CNT_W_UNUSED = CNT_W;
`endif
endmodule
